// File: rtl/imem_loader.sv
// Byte-stream program loader: fills instruction memory from a framed byte stream
// and releases the core from reset only after the frame checksum verifies.
`timescale 1ns/1ps
module imem_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid_i,
  input  logic [7:0]            s_data_i,
  output logic                  s_ready_o,
  output logic                  imem_we_o,
  output logic [ADDR_WIDTH-1:0] imem_addr_o,
  output logic [DATA_WIDTH-1:0] imem_wdata_o,
  output logic                  core_rst_no,
  output logic                  done_o,
  output logic                  error_o
);

  typedef enum logic [2:0] {
    S_HDR0, S_HDR1, S_DATA, S_CSUM, S_DONE, S_ERROR
  } state_e;

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  state_e                  state_q;
  logic [15:0]             cnt_q;
  logic [15:0]             word_cnt_q;
  logic [1:0]              idx_q;
  logic [DATA_WIDTH-9:0]   word_q;    // first three bytes of the word in flight
  logic [7:0]              csum_q;
  logic                    we_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic                    done_q;
  logic                    error_q;
  logic                    core_rst_q;

  logic        accept;
  logic [7:0]  csum_d;
  logic [15:0] cnt_d;

  // Ready is gated by rst_n directly so it is 0 during reset and 1 right after release.
  assign s_ready_o = rst_n && (state_q != S_DONE) && (state_q != S_ERROR);
  assign accept    = s_valid_i && s_ready_o;
  assign csum_d    = csum_q ^ s_data_i;
  assign cnt_d     = {s_data_i, cnt_q[7:0]};

  // NOTE: every register here uses <= so all updates see the pre-edge values;
  // blocking assignments would make later statements read already-updated state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_HDR0;
      cnt_q      <= '0;
      word_cnt_q <= '0;
      idx_q      <= '0;
      word_q     <= '0;
      csum_q     <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      core_rst_q <= 1'b0;
    end else begin
      we_q <= 1'b0;
      if (accept) begin
        case (state_q)
          S_HDR0: begin
            cnt_q[7:0] <= s_data_i;
            csum_q     <= csum_d;
            state_q    <= S_HDR1;
          end
          S_HDR1: begin
            cnt_q[15:8] <= s_data_i;
            csum_q      <= csum_d;
            if (cnt_d == 16'd0) begin
              state_q <= S_CSUM;
            end else if (32'(cnt_d) > DEPTH) begin
              state_q <= S_ERROR;
              error_q <= 1'b1;
            end else begin
              state_q <= S_DATA;
            end
          end
          S_DATA: begin
            csum_q <= csum_d;
            word_q <= {s_data_i, word_q[DATA_WIDTH-9:8]};
            idx_q  <= idx_q + 2'd1;
            if (idx_q == 2'd3) begin
              we_q       <= 1'b1;
              addr_q     <= word_cnt_q[ADDR_WIDTH-1:0];
              wdata_q    <= {s_data_i, word_q};
              word_cnt_q <= word_cnt_q + 16'd1;
              if (word_cnt_q == cnt_q - 16'd1) state_q <= S_CSUM;
            end
          end
          S_CSUM: begin
            if (s_data_i == csum_q) begin
              state_q    <= S_DONE;
              done_q     <= 1'b1;
              core_rst_q <= 1'b1;
            end else begin
              state_q <= S_ERROR;
              error_q <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign imem_we_o    = we_q;
  assign imem_addr_o  = addr_q;
  assign imem_wdata_o = wdata_q;
  assign done_o       = done_q;
  assign error_o      = error_q;
  assign core_rst_no  = core_rst_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus pushes expected writes, a monitor
// pops them on every write strobe; completion flags are checked after each frame.
`timescale 1ns/1ps
module tb_imem_loader;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_valid_i = 1'b0;
  logic [7:0]    s_data_i = 8'h00;
  logic          s_ready_o;
  logic          imem_we_o;
  logic [AW-1:0] imem_addr_o;
  logic [31:0]   imem_wdata_o;
  logic          core_rst_no;
  logic          done_o;
  logic          error_o;

  imem_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_valid_i    (s_valid_i),
    .s_data_i     (s_data_i),
    .s_ready_o    (s_ready_o),
    .imem_we_o    (imem_we_o),
    .imem_addr_o  (imem_addr_o),
    .imem_wdata_o (imem_wdata_o),
    .core_rst_no  (core_rst_no),
    .done_o       (done_o),
    .error_o      (error_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         mon_e;
  logic [31:0] frame_words[$];
  int          checks = 0;
  int          failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (done_o && error_o) begin
      failures++;
      $display("FAIL done_error_both: done=1 error=1 expected at most one set");
    end
    if (imem_we_o) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write: got addr=%h data=%h expected no write",
                 imem_addr_o, imem_wdata_o);
      end else begin
        mon_e = exp_q.pop_front();
        if (imem_addr_o !== mon_e.addr || imem_wdata_o !== mon_e.data) begin
          failures++;
          $display("FAIL write: got addr=%h data=%h expected addr=%h data=%h",
                   imem_addr_o, imem_wdata_o, mon_e.addr, mon_e.data);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    s_valid_i = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_we",       imem_we_o,    0);
    check("rst_addr",     imem_addr_o,  0);
    check("rst_wdata",    imem_wdata_o, 0);
    check("rst_core_rst", core_rst_no,  0);
    check("rst_done",     done_o,       0);
    check("rst_error",    error_o,      0);
    check("rst_ready",    s_ready_o,    0);
    rst_n = 1'b1;
    #1;
    check("ready_after_rst", s_ready_o, 1);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gapmax);
    int g;
    g = (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0;
    repeat (g) begin
      @(negedge clk);
      s_valid_i = 1'b0;
    end
    @(negedge clk);
    s_valid_i = 1'b1;
    s_data_i  = b;
    @(posedge clk);
  endtask

  // Sends header, nwords payload words from frame_words and optionally the
  // checksum (XORed with chk_mask to corrupt it); returns at the negedge after the last byte.
  task automatic send_frame(input logic [15:0] n, input int nwords, input int gapmax,
                            input bit send_chk, input logic [7:0] chk_mask);
    logic [7:0]  x;
    logic [7:0]  b;
    logic [31:0] w;
    wr_t         e;
    x = 8'h00;
    send_byte(n[7:0], gapmax);  x ^= n[7:0];
    send_byte(n[15:8], gapmax); x ^= n[15:8];
    for (int k = 0; k < nwords; k++) begin
      w = frame_words[k];
      for (int j = 0; j < 4; j++) begin
        b = w[8*j +: 8];
        if (j == 3) begin
          e.addr = k[AW-1:0];
          e.data = w;
          exp_q.push_back(e);
        end
        send_byte(b, gapmax);
        x ^= b;
      end
    end
    if (send_chk) send_byte(x ^ chk_mask, gapmax);
    @(negedge clk);
    s_valid_i = 1'b0;
  endtask

  // Checked one cycle after the final accepting edge, then again after idle traffic.
  task automatic finish_checks(input string name, input logic exp_done, input logic exp_err);
    check({name, "_done"},     done_o,      exp_done);
    check({name, "_error"},    error_o,     exp_err);
    check({name, "_core_rst"}, core_rst_no, exp_done);
    check({name, "_ready"},    s_ready_o,   0);
    check({name, "_drained"},  exp_q.size(), 0);
    s_valid_i = 1'b1;
    s_data_i  = 8'h55;
    repeat (3) @(negedge clk);
    s_valid_i = 1'b0;
    check({name, "_ready_hold"}, s_ready_o, 0);
    check({name, "_done_hold"},  done_o,    exp_done);
    check({name, "_error_hold"}, error_o,   exp_err);
  endtask

  initial begin
    // One word, back-to-back: 01 00 33 03 94 00 A5.
    do_reset();
    frame_words = '{32'h00940333};
    send_frame(16'd1, 1, 0, 1'b1, 8'h00);
    finish_checks("one_word", 1'b1, 1'b0);

    // Same frame with CHK = A4.
    do_reset();
    send_frame(16'd1, 1, 0, 1'b1, 8'h01);
    finish_checks("bad_chk", 1'b0, 1'b1);

    // Eight-word program with random valid gaps.
    do_reset();
    frame_words = '{32'h00500093, 32'h00a00113, 32'h002081b3, 32'h00302023,
                    32'h00002203, 32'h00418263, 32'h0000006f, 32'h00000013};
    send_frame(16'd8, 8, 3, 1'b1, 8'h00);
    finish_checks("eight_words", 1'b1, 1'b0);

    // Empty program: 00 00 00.
    do_reset();
    send_frame(16'd0, 0, 0, 1'b1, 8'h00);
    finish_checks("empty", 1'b1, 1'b0);

    // Oversize count 257: rejected right after CNT_HI.
    do_reset();
    send_frame(16'd257, 0, 0, 1'b0, 8'h00);
    finish_checks("oversize", 1'b0, 1'b1);

    // Full memory: 256 words ending at address 255.
    do_reset();
    frame_words.delete();
    for (int i = 0; i < 256; i++)
      frame_words.push_back({i[7:0] ^ 8'hA5, i[7:0], ~i[7:0], 8'h3C ^ i[7:0]});
    send_frame(16'd256, 256, 0, 1'b1, 8'h00);
    finish_checks("full", 1'b1, 1'b0);

    // Reset after two payload bytes: no write, then a fresh frame loads cleanly.
    do_reset();
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h33, 0);
    send_byte(8'h03, 0);
    do_reset();
    repeat (3) @(negedge clk);
    check("abort_no_write_pending", exp_q.size(), 0);
    frame_words = '{32'h00940333};
    send_frame(16'd1, 1, 0, 1'b1, 8'h00);
    finish_checks("after_abort", 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
